pe_request_unit: RTL and testbench



---
 rtl/pe_request_unit_if.sv | 28 ++
 rtl/pe_request_unit.sv | 130 +++++++++++++
 tb/tb_pe_request_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_request_unit_if.sv
// PE-side and arbiter-side signals of the injection request unit, bundled for port hookup.
// The master modport is the request unit itself; the slave modport is its environment.
interface pe_request_unit_if #(
    parameter int FLIT_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  pe_valid;
    logic [FLIT_WIDTH-1:0] pe_flit;
    logic                  pe_ready;
    logic [2:0]            pe_request_bundle;
    logic                  r2pe_ack;
    logic [FLIT_WIDTH-1:0] flit_dout;
    logic                  self_drop;
    logic                  starve;
    logic [CW-1:0]         fifo_count;

    modport master (
        input  pe_valid, pe_flit, r2pe_ack,
        output pe_ready, pe_request_bundle, flit_dout, self_drop, starve, fifo_count
    );

    modport slave (
        output pe_valid, pe_flit, r2pe_ack,
        input  pe_ready, pe_request_bundle, flit_dout, self_drop, starve, fifo_count
    );
endinterface

// File: rtl/pe_request_unit.sv
// Injection-side initiator: buffers PE flits, stages the head with its routing hit bits,
// and holds the request to the arbiter until acked; self-addressed flits are discarded.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | nothing staged; pop the FIFO head when one is present
//   ST_REQ   | staged flit is requested; waits for r2pe_ack
//   ST_DROP  | staged flit was self-addressed; pulse self_drop, discard
module pe_request_unit #(
    parameter int X_ADDR       = 0,
    parameter int Y_ADDR       = 0,
    parameter int ADDR_WIDTH   = 3,
    parameter int FLIT_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pe_request_unit_if.master       bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [FLIT_WIDTH-1:0] r_flit;
    logic                  r_hit_x;
    logic                  r_hit_y;
    logic [WW-1:0]         r_wait;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;
    logic                  w_advance;
    logic                  w_req;
    logic [FLIT_WIDTH-1:0] w_head;
    logic                  w_head_hx;
    logic                  w_head_hy;

    assign w_nonempty = (r_count != '0);
    assign bus.pe_ready = (r_count != CW'(FIFO_DEPTH));
    assign w_push     = bus.pe_valid && bus.pe_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_hx  = (w_head[FLIT_WIDTH-1 -: ADDR_WIDTH] == ADDR_WIDTH'(X_ADDR));
    assign w_head_hy  = (w_head[FLIT_WIDTH-1-ADDR_WIDTH -: ADDR_WIDTH] == ADDR_WIDTH'(Y_ADDR));

    // REQ only moves on when acked; IDLE and DROP always take the next head if present.
    assign w_advance = (r_state != ST_REQ) || bus.r2pe_ack;

    always_comb begin
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        if (w_advance) begin
            if (w_nonempty) begin
                w_pop       = 1'b1;
                w_state_nxt = (w_head_hx && w_head_hy) ? ST_DROP : ST_REQ;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.pe_flit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flit  <= '0;
            r_hit_x <= 1'b0;
            r_hit_y <= 1'b0;
        end else if (w_pop) begin
            r_flit  <= w_head;
            r_hit_x <= w_head_hx;
            r_hit_y <= w_head_hy;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
        end else if ((r_state == ST_REQ) && !bus.r2pe_ack) begin
            if (r_wait != WW'(STARVE_LIMIT)) r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    assign w_req                 = (r_state == ST_REQ);
    assign bus.pe_request_bundle = {w_req & r_hit_x, w_req & r_hit_y, w_req};
    assign bus.flit_dout         = r_flit;
    assign bus.self_drop         = (r_state == ST_DROP);
    assign bus.starve            = w_req && (r_wait >= WW'(STARVE_LIMIT));
    assign bus.fifo_count        = r_count;

endmodule

// File: tb/tb_pe_request_unit.sv
// Directed bench for pe_request_unit at router (2,2): single-flit vector table plus
// hand-written sequences for self-drop, full FIFO, starvation and mid-request reset.
module tb_pe_request_unit;
    localparam int FW = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    pe_request_unit_if #(.FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH)) bus ();

    pe_request_unit #(
        .X_ADDR(2), .Y_ADDR(2), .ADDR_WIDTH(3), .FLIT_WIDTH(FW),
        .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(15)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] dx;
        logic [2:0] dy;
        logic [9:0] pay;
        int         hold;
        logic [2:0] exp_bundle;
        logic       exp_drop;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [FW-1:0] mk(input logic [2:0] x, input logic [2:0] y,
                                         input logic [9:0] p);
        return {x, y, p};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [FW-1:0] exp_q [5];
    logic [FW-1:0] f;
    int            drops;
    int            accepted;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.pe_valid = 1'b0;
        bus.pe_flit  = '0;
        bus.r2pe_ack = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_bundle", 32'(bus.pe_request_bundle), 32'h0);
        chk("rst_flit",   32'(bus.flit_dout), 32'h0);
        chk("rst_drop",   32'(bus.self_drop), 32'h0);
        chk("rst_starve", 32'(bus.starve), 32'h0);
        chk("rst_count",  32'(bus.fifo_count), 32'h0);
        chk("rst_ready",  32'(bus.pe_ready), 32'h1);
        #10 reset_n = 1'b1;
        step(); step();
        chk("post_rst_bundle", 32'(bus.pe_request_bundle), 32'h0);
        chk("post_rst_count",  32'(bus.fifo_count), 32'h0);

        vecs[0] = '{3'd0, 3'd5, 10'h011, 0, 3'b001, 1'b0};
        vecs[1] = '{3'd2, 3'd5, 10'h022, 2, 3'b101, 1'b0};
        vecs[2] = '{3'd3, 3'd2, 10'h033, 5, 3'b011, 1'b0};
        vecs[3] = '{3'd2, 3'd2, 10'h044, 0, 3'b000, 1'b1};
        vecs[4] = '{3'd0, 3'd0, 10'h055, 1, 3'b001, 1'b0};

        for (int i = 0; i < 5; i++) begin
            f = mk(vecs[i].dx, vecs[i].dy, vecs[i].pay);
            bus.pe_valid = 1'b1;
            bus.pe_flit  = f;
            step();
            bus.pe_valid = 1'b0;
            chk("v_count_after_push", 32'(bus.fifo_count), 32'd1);
            step();
            chk("v_bundle", 32'(bus.pe_request_bundle), 32'(vecs[i].exp_bundle));
            chk("v_drop",   32'(bus.self_drop), 32'(vecs[i].exp_drop));
            if (!vecs[i].exp_drop) begin
                chk("v_flit", 32'(bus.flit_dout), 32'(f));
                for (int h = 0; h < vecs[i].hold; h++) begin
                    step();
                    chk("v_hold_bundle", 32'(bus.pe_request_bundle), 32'(vecs[i].exp_bundle));
                    chk("v_hold_flit",   32'(bus.flit_dout), 32'(f));
                end
                bus.r2pe_ack = 1'b1;
                step();
                bus.r2pe_ack = 1'b0;
            end else begin
                step();
            end
            chk("v_bundle_done", 32'(bus.pe_request_bundle), 32'h0);
            chk("v_drop_done",   32'(bus.self_drop), 32'h0);
            chk("v_count_done",  32'(bus.fifo_count), 32'h0);
        end

        // Self-addressed flit followed by (0,0), back to back
        drops = 0;
        bus.pe_valid = 1'b1;
        bus.pe_flit  = mk(3'd2, 3'd2, 10'h0AA);
        step();
        bus.pe_flit  = mk(3'd0, 3'd0, 10'h0BB);
        step();
        bus.pe_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.self_drop) drops++;
            chk("sd_no_req_for_self",
                32'(bus.pe_request_bundle[0] && (bus.flit_dout == mk(3'd2, 3'd2, 10'h0AA))), 32'h0);
            if (c >= 1) begin
                chk("sd_next_bundle", 32'(bus.pe_request_bundle), 32'b001);
                chk("sd_next_flit",   32'(bus.flit_dout), 32'(mk(3'd0, 3'd0, 10'h0BB)));
            end
            step();
        end
        chk("sd_drop_pulses", 32'(drops), 32'd1);
        bus.r2pe_ack = 1'b1;
        step();
        bus.r2pe_ack = 1'b0;
        chk("sd_bundle_done", 32'(bus.pe_request_bundle), 32'h0);

        // Full FIFO: six offers, no acks
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            bus.pe_valid = 1'b1;
            bus.pe_flit  = mk(3'd1, 3'd1, 10'(10'h100 + k));
            if (bus.pe_ready) begin
                exp_q[accepted] = bus.pe_flit;
                accepted++;
            end
            step();
        end
        bus.pe_valid = 1'b0;
        chk("full_accepted", 32'(accepted), 32'd5);
        chk("full_count",    32'(bus.fifo_count), 32'd4);
        chk("full_ready",    32'(bus.pe_ready), 32'h0);
        bus.r2pe_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("full_stream_req",  32'(bus.pe_request_bundle), 32'b001);
            chk("full_stream_flit", 32'(bus.flit_dout), 32'(exp_q[k]));
            step();
        end
        bus.r2pe_ack = 1'b0;
        chk("full_drained_bundle", 32'(bus.pe_request_bundle), 32'h0);
        chk("full_drained_count",  32'(bus.fifo_count), 32'h0);

        // Starvation
        bus.pe_valid = 1'b1;
        bus.pe_flit  = mk(3'd4, 3'd4, 10'h3C3);
        step();
        bus.pe_valid = 1'b0;
        step();
        chk("st_req", 32'(bus.pe_request_bundle), 32'b001);
        chk("st_initial", 32'(bus.starve), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("st_wait", 32'(bus.starve), (k >= 15) ? 32'h1 : 32'h0);
        end
        bus.r2pe_ack = 1'b1;
        step();
        bus.r2pe_ack = 1'b0;
        chk("st_cleared", 32'(bus.starve), 32'h0);
        chk("st_bundle_done", 32'(bus.pe_request_bundle), 32'h0);

        // Reset while requesting with 3 flits buffered
        for (int k = 0; k < 4; k++) begin
            bus.pe_valid = 1'b1;
            bus.pe_flit  = mk(3'd5, 3'd6, 10'(10'h200 + k));
            step();
        end
        bus.pe_valid = 1'b0;
        chk("rr_count_before", 32'(bus.fifo_count), 32'd3);
        chk("rr_req_before",   32'(bus.pe_request_bundle), 32'b001);
        #2 reset_n = 1'b0;
        #1;
        chk("rr_bundle", 32'(bus.pe_request_bundle), 32'h0);
        chk("rr_count",  32'(bus.fifo_count), 32'h0);
        chk("rr_ready",  32'(bus.pe_ready), 32'h1);
        chk("rr_drop",   32'(bus.self_drop), 32'h0);
        #10 reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_idle_bundle", 32'(bus.pe_request_bundle), 32'h0);
            chk("rr_idle_drop",   32'(bus.self_drop), 32'h0);
        end
        chk("rr_idle_count", 32'(bus.fifo_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
